// File: rtl/regs_load_scoreboard.sv
// Load write-back sequencer and register hazard scoreboard for write port 3.
// Latency: response -> we3 one cycle later; issue -> pending/stall visible next cycle.
// Backpressure: issue_ready drops when the rd queue is full or issue_rd is still pending; responses are never stalled.

// Small generic FIFO with occupancy count; no bypass, no same-cycle credit.
module regs_load_scoreboard_fifo #(
  parameter int DW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_vld,
  input  logic [DW-1:0]              wr_dat,
  input  logic                       rd_vld,
  output logic [DW-1:0]              rd_dat,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DW-1:0]    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array: written on push, no reset needed since count gates reads.
  always_ff @(posedge clk) begin
    if (wr_vld) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_vld) wr_ptr <= wr_ptr + 1'b1;
      if (rd_vld) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_vld && !rd_vld) begin
      count <= count + 1'b1;
    end else if (!wr_vld && rd_vld) begin
      count <= count - 1'b1;
    end
  end

  assign rd_dat = mem[rd_ptr];

endmodule

module regs_load_scoreboard #(
  parameter int ADDR_WIDTH = 5,
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_rd,
  output logic                       issue_ready,
  input  logic                       resp_valid,
  input  logic [WIDTH-1:0]           resp_data,
  output logic [ADDR_WIDTH-1:0]      ra3,
  output logic [WIDTH-1:0]           wd3,
  output logic                       we3,
  input  logic [ADDR_WIDTH-1:0]      q_rs1,
  input  logic [ADDR_WIDTH-1:0]      q_rs2,
  input  logic [ADDR_WIDTH-1:0]      q_rd,
  output logic                       stall,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int NREG  = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_nxt;
  logic [ADDR_WIDTH-1:0] head_rd;
  logic                  push;
  logic                  pop;
  logic                  q_empty;

  assign q_empty = (count == '0);

  // Issue credit comes from registered state only, so a pop in the same
  // cycle never frees a slot early.
  assign issue_ready = (count < DEPTH_C) && !pending[issue_rd];
  assign push        = issue_valid && issue_ready;
  assign pop         = resp_valid && !q_empty;

  regs_load_scoreboard_fifo #(
    .DW    (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_rd_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push),
    .wr_dat (issue_rd),
    .rd_vld (pop),
    .rd_dat (head_rd),
    .count  (count)
  );

  // Pending vector update: write-back clears, accepted issue sets. They never
  // hit the same register because a pending rd cannot be issued again.
  always_comb begin
    pending_nxt = pending;
    if (we3) begin
      pending_nxt[ra3] = 1'b0;
    end
    if (push && (issue_rd != '0)) begin
      pending_nxt[issue_rd] = 1'b1;
    end
  end

  // Pending register state; x0 is never marked.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Write-back stage: capture the head rd with the response data; address and
  // data hold when idle so only we3 toggles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we3 <= 1'b0;
      ra3 <= '0;
      wd3 <= '0;
    end else if (pop) begin
      we3 <= 1'b1;
      ra3 <= head_rd;
      wd3 <= resp_data;
    end else begin
      we3 <= 1'b0;
    end
  end

  // Sticky flag for a response that had no outstanding load to match.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (resp_valid && q_empty) begin
      err <= 1'b1;
    end
  end

  // Decoder hazard: any source or destination still waiting on a load.
  // The destination term blocks an ALU write from overtaking an older load.
  assign stall = ((q_rs1 != '0) && pending[q_rs1])
               | ((q_rs2 != '0) && pending[q_rs2])
               | ((q_rd  != '0) && pending[q_rd]);

endmodule
